// File: rtl/axis_burst_fifo.sv
// Synchronous FIFO with combinational head read, used to queue beats (data plus last flag)
// between the staging register and the output serialiser.
module axis_burst_fifo #(
  parameter int unsigned WIDTH      = 129,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;

  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/axis_burst_serializer.sv
// Absorbs non-stallable 128-bit bursts, queues them, and serialises each beat into narrower
// AXI4-Stream words with tlast on the final word of each burst. Overflow drops beats.
module axis_burst_serializer #(
  parameter int unsigned IN_WIDTH   = 128,
  parameter int unsigned OUT_WIDTH  = 32,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [IN_WIDTH-1:0]   s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic [OUT_WIDTH-1:0]  m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  input  logic                  clr,
  output logic                  overflow,
  output logic [15:0]           drop_cnt,
  output logic [DEPTH_LOG2:0]   fill
);

  localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  // Staging register: a beat's last flag is only known one cycle later.
  logic                stage_valid_q;
  logic [IN_WIDTH-1:0] stage_data_q;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
  logic [IN_WIDTH:0]   fifo_rdata;

  logic                out_valid_q, out_valid_d;
  logic [IN_WIDTH-1:0] out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic                overflow_q;
  logic [15:0]         drop_cnt_q;

  logic [RATIO-1:0][OUT_WIDTH-1:0] out_words;

  always_ff @(posedge aclk) begin
    if (areset) begin
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
    end else begin
      stage_valid_q <= s_axis_tvalid;
      stage_data_q  <= s_axis_tdata;
    end
  end

  // Full is judged on the registered count, so a same-cycle pop cannot rescue a commit.
  assign fifo_push = stage_valid_q & ~fifo_full;
  assign drop      = stage_valid_q & fifo_full;

  axis_burst_fifo #(
    .WIDTH      (IN_WIDTH + 1),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .aclk   (aclk),
    .areset (areset),
    .push   (fifo_push),
    .wdata  ({~s_axis_tvalid, stage_data_q}),
    .pop    (fifo_pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fill)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    idx_d       = idx_q;
    fifo_pop    = 1'b0;
    if (!out_valid_q || (m_axis_tready && idx_q == LAST_IDX)) begin
      if (!fifo_empty) begin
        fifo_pop    = 1'b1;
        out_valid_d = 1'b1;
        out_data_d  = fifo_rdata[IN_WIDTH-1:0];
        out_last_d  = fifo_rdata[IN_WIDTH];
        idx_d       = '0;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (m_axis_tready) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      idx_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      idx_q       <= idx_d;
    end
  end

  // A drop takes precedence over a coincident clear.
  always_ff @(posedge aclk) begin
    if (areset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (clr) begin
        drop_cnt_q <= 16'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end else if (clr) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end
  end

  assign out_words     = out_data_q;
  assign m_axis_tdata  = out_words[idx_q];
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q & (idx_q == LAST_IDX);
  assign overflow      = overflow_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_axis_burst_serializer.sv
// Bench for axis_burst_serializer: directed scenarios plus random traffic, all checked
// against a queue-based transaction model of the serialiser.
module tb_axis_burst_serializer;

  localparam int DEPTH = 16;
  localparam int RATIO = 4;

  logic         aclk = 1'b0;
  logic         areset;
  logic [127:0] s_axis_tdata;
  logic         s_axis_tvalid;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic         clr;
  logic         overflow;
  logic [15:0]  drop_cnt;
  logic [4:0]   fill;

  axis_burst_serializer #(
    .IN_WIDTH   (128),
    .OUT_WIDTH  (32),
    .DEPTH_LOG2 (4)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .clr           (clr),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt),
    .fill          (fill)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction model: staged beat, queue of {last,data}, beat being sent and its word index.
  logic         m_sv;
  logic [127:0] m_sd;
  logic [128:0] mq[$];
  logic         m_ov;
  logic [127:0] m_beat;
  logic         m_last;
  int           m_idx;
  logic         m_ovf;
  int           m_cnt;

  // Observed statistics for directed checks.
  int           cyc = 0;
  int           words, lasts, last_pos, first_valid_edge, last_xfer_edge, max_fill;
  bit           seen_first;
  logic [31:0]  wlog[$];

  task automatic model_reset();
    m_sv = 1'b0; m_sd = '0; mq.delete();
    m_ov = 1'b0; m_beat = '0; m_last = 1'b0; m_idx = 0;
    m_ovf = 1'b0; m_cnt = 0;
  endtask

  task automatic clear_stats();
    words = 0; lasts = 0; last_pos = 0; first_valid_edge = -1; last_xfer_edge = -1;
    max_fill = 0; seen_first = 0; wlog.delete();
  endtask

  task automatic model_step(input logic tv, input logic [127:0] td, input logic tr,
                            input logic c, input logic rst);
    logic [128:0] h;
    bit           full_pre;
    bit           had;
    if (rst) begin
      model_reset();
      return;
    end
    full_pre = (mq.size() == DEPTH);
    had      = (mq.size() > 0);
    if (!m_ov || (tr && m_idx == RATIO - 1)) begin
      if (had) begin
        h = mq.pop_front();
        m_ov = 1'b1; m_beat = h[127:0]; m_last = h[128]; m_idx = 0;
      end else begin
        m_ov = 1'b0;
      end
    end else if (tr) begin
      m_idx++;
    end
    if (m_sv && full_pre) begin
      m_ovf = 1'b1;
      m_cnt = c ? 1 : ((m_cnt == 65535) ? 65535 : m_cnt + 1);
    end else begin
      if (m_sv) mq.push_back({~tv, m_sd});
      if (c) begin
        m_ovf = 1'b0;
        m_cnt = 0;
      end
    end
    m_sv = tv;
    m_sd = td;
  endtask

  // One clock: check current outputs, apply inputs, advance model, move to next negedge.
  task automatic cycle(input logic tv, input logic [127:0] td, input logic tr,
                       input logic c, input logic rst);
    logic [31:0] exp_d;
    exp_d = m_beat[m_idx*32 +: 32];
    check_eq("tvalid", 64'(m_axis_tvalid), 64'(m_ov));
    if (m_ov) begin
      check_eq("tdata", 64'(m_axis_tdata), 64'(exp_d));
      check_eq("tlast", 64'(m_axis_tlast), 64'(m_last && m_idx == RATIO - 1));
    end
    check_eq("fill", 64'(fill), 64'(mq.size()));
    check_eq("overflow", 64'(overflow), 64'(m_ovf));
    check_eq("drop_cnt", 64'(drop_cnt), 64'(m_cnt));
    if (m_axis_tvalid === 1'b1) begin
      if (!seen_first) begin
        seen_first = 1;
        first_valid_edge = cyc;
      end
      if (tr) begin
        wlog.push_back(m_axis_tdata);
        words++;
        last_xfer_edge = cyc + 1;
        if (m_axis_tlast === 1'b1) begin
          lasts++;
          last_pos = words;
        end
      end
    end
    if (int'(fill) > max_fill) max_fill = int'(fill);
    s_axis_tvalid = tv;
    s_axis_tdata  = td;
    m_axis_tready = tr;
    clr           = c;
    areset        = rst;
    model_step(tv, td, tr, c, rst);
    @(posedge aclk);
    cyc++;
    @(negedge aclk);
  endtask

  task automatic idle(input int n, input bit toggle, input logic tr);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, '0, toggle ? logic'(i % 2 == 0) : tr, 1'b0, 1'b0);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] beats[$];
  logic [127:0] a, b, cc, d, e, f, g, hh;
  int           a_edge;

  initial begin
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b0; clr = 1'b0;
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    model_reset();
    check_eq("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_eq("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check_eq("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check_eq("rst_overflow", 64'(overflow), 64'd0);
    check_eq("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check_eq("rst_fill", 64'(fill), 64'd0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle(2, 0, 1'b1);

    // 3-beat burst, tready=1
    clear_stats();
    a = rnd128(); b = rnd128(); cc = rnd128();
    a_edge = cyc + 1;
    cycle(1'b1, a, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, b, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, cc, 1'b1, 1'b0, 1'b0);
    idle(20, 0, 1'b1);
    check_eq("t1_words", 64'(words), 64'd12);
    check_eq("t1_lasts", 64'(lasts), 64'd1);
    check_eq("t1_last_pos", 64'(last_pos), 64'd12);
    check_eq("t1_latency", 64'(first_valid_edge - a_edge), 64'd2);
    check_eq("t1_first_word", 64'(wlog[0]), 64'(a[31:0]));
    check_eq("t1_final_word", 64'(wlog[11]), 64'(cc[127:96]));

    // 1-beat burst, tready toggling
    clear_stats();
    d = rnd128();
    cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
    idle(24, 1, 1'b0);
    check_eq("t2_words", 64'(words), 64'd4);
    check_eq("t2_lasts", 64'(lasts), 64'd1);
    check_eq("t2_last_pos", 64'(last_pos), 64'd4);
    check_eq("t2_final_word", 64'(wlog[3]), 64'(d[127:96]));

    // DEPTH+4 contiguous beats with tready=0
    clear_stats();
    beats.delete();
    for (int i = 0; i < DEPTH + 4; i++) begin
      beats.push_back(rnd128());
      cycle(1'b1, beats[i], 1'b0, 1'b0, 1'b0);
    end
    idle(2, 0, 1'b0);
    check_eq("t3_drop_cnt", 64'(drop_cnt), 64'd3);
    check_eq("t3_overflow", 64'(overflow), 64'd1);
    check_eq("t3_fill", 64'(fill), 64'(DEPTH));
    check_eq("t3_tvalid", 64'(m_axis_tvalid), 64'd1);

    // clr without and with a coincident drop
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_eq("t4_clr_overflow", 64'(overflow), 64'd0);
    check_eq("t4_clr_drop_cnt", 64'(drop_cnt), 64'd0);
    cycle(1'b1, rnd128(), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check_eq("t4_drop_overflow", 64'(overflow), 64'd1);
    check_eq("t4_drop_drop_cnt", 64'(drop_cnt), 64'd1);

    idle(80, 0, 1'b1);
    check_eq("t3_drain_words", 64'((DEPTH + 1) * 4), 64'(words));
    check_eq("t3_drain_lasts", 64'(lasts), 64'd0);
    if (words == (DEPTH + 1) * 4) begin
      for (int i = 0; i <= DEPTH; i++) begin
        for (int w = 0; w < RATIO; w++) begin
          check_eq("t3_order", 64'(wlog[i*RATIO+w]), 64'(beats[i][w*32 +: 32]));
        end
      end
    end

    // Two 1-beat bursts separated by one idle cycle
    clear_stats();
    e = rnd128(); f = rnd128();
    cycle(1'b1, e, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, f, 1'b1, 1'b0, 1'b0);
    idle(16, 0, 1'b1);
    check_eq("t5_words", 64'(words), 64'd8);
    check_eq("t5_lasts", 64'(lasts), 64'd2);
    check_eq("t5_last_pos", 64'(last_pos), 64'd8);
    check_eq("t5_max_fill", 64'(max_fill), 64'd1);
    check_eq("t5_no_bubble", 64'(last_xfer_edge - first_valid_edge), 64'd8);

    // Reset mid-burst with two beats queued
    clear_stats();
    for (int i = 0; i < 4; i++) cycle(1'b1, rnd128(), 1'b0, 1'b0, 1'b0);
    check_eq("t6_fill_before", 64'(fill), 64'd2);
    cycle(1'b1, rnd128(), 1'b0, 1'b0, 1'b1);
    check_eq("t6_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_eq("t6_tlast", 64'(m_axis_tlast), 64'd0);
    check_eq("t6_tdata", 64'(m_axis_tdata), 64'd0);
    check_eq("t6_fill", 64'(fill), 64'd0);
    check_eq("t6_overflow", 64'(overflow), 64'd0);
    check_eq("t6_drop_cnt", 64'(drop_cnt), 64'd0);
    clear_stats();
    g = rnd128(); hh = rnd128();
    cycle(1'b1, g, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, hh, 1'b1, 1'b0, 1'b0);
    idle(16, 0, 1'b1);
    check_eq("t6_words", 64'(words), 64'd8);
    check_eq("t6_lasts", 64'(lasts), 64'd1);
    check_eq("t6_last_pos", 64'(last_pos), 64'd8);
    check_eq("t6_first_word", 64'(wlog[0]), 64'(g[31:0]));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(logic'($urandom_range(0, 99) < 30), rnd128(),
            logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 63) == 0),
            logic'($urandom_range(0, 999) == 0));
    end
    idle(100, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
